fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the single-issue MIPS pipeline, directly upstream of the main control decoder.
//  Owns the PC and drives a req/ack instruction-memory port.
//  Fills the IF/ID register and exposes its opcode field (instr[31:26]) to the decoder.
//  Takes stall from hazard logic and branch/jump redirects from later stages.
// PARAMETERS
//  PC_WIDTH   32      width of PC, addresses and pc4
//  RESET_PC   32'h0   PC loaded by reset; bits[1:0] must be 0
// PORTS
//  clk             in   1         single clock; all state updates on rising edge
//  rst             in   1         synchronous, active-high reset
//  imem_req        out  1         fetch request
//  imem_addr       out  PC_WIDTH  fetch address (word aligned)
//  imem_ack        in   1         1-cycle pulse: imem_rdata valid, request complete
//  imem_rdata      in   32        fetched instruction
//  stall           in   1         hold IF/ID and PC (load-use hazard)
//  flush           in   1         squash IF/ID contents
//  redirect_valid  in   1         taken branch / jump
//  redirect_pc     in   PC_WIDTH  target; bits[1:0] ignored (forced 0)
//  ifid_valid      out  1         IF/ID holds a live instruction
//  ifid_instr      out  32        IF/ID instruction; 32'h0 (nop) when !ifid_valid
//  ifid_pc4        out  PC_WIDTH  address of ifid_instr + 4
//  opcode          out  6         ifid_instr[31:26], feeds control decoder
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, ifid_valid=0, ifid_instr=0, ifid_pc4=0, hold buffer cleared.
//  imem_req=0 while rst=1.
//  Bubble is instr 32'h0 (sll $0,$0,0) -> opcode 6'b000000.
//  Never present a bubble as a non-R opcode.
//  Mem protocol:
//   - imem_req=1 with imem_addr=pc in FETCH and DRAIN; both stable until imem_ack.
//   - ack may arrive in the same cycle as req (zero wait) or any later cycle.
//   - No request is ever abandoned.
//  FSM FETCH:
//   - ack & !stall -> IF/ID<={1,rdata,pc+4}, pc<=pc+4, stay FETCH (1 instr/cycle at zero wait).
//   - ack & stall -> rdata to hold buffer, pc unchanged, ->HOLD.
//   - !ack -> stay FETCH, req held.
//  FSM HOLD: imem_req=0.
//   - !stall -> IF/ID<=buffer, pc<=pc+4, ->FETCH.
//  FSM DRAIN: fetch to stale pc still in flight after a redirect.
//   - imem_addr holds the stale address.
//   - on ack discard rdata, ->FETCH.
//  Redirect (highest priority, any state):
//   - pc<={redirect_pc[PC_WIDTH-1:2],2'b00}; IF/ID squashed (valid=0, instr=0).
//   - Request in flight with no ack this cycle -> DRAIN. Otherwise (ack this cycle, HOLD, or DRAIN+ack) -> FETCH.
//   - Any ack data in the redirect cycle is discarded; hold buffer is dropped.
//   - DRAIN & redirect & !ack -> stay DRAIN, newest target wins.
//  Flush (no redirect):
//   - IF/ID squashed; pc and FSM unaffected.
//   - Flush beats stall and beats an ack load into IF/ID in the same cycle.
//   - The acked instr still goes to the hold buffer if stalled, else is dropped with pc<=pc+4.
//  Stall: IF/ID holds its value; PC advances only per the FSM rules above.
//  Arithmetic: pc+4 wraps modulo 2^PC_WIDTH; redirect to 0 is legal.
//  Reset mid-operation: in-flight request is forgotten; memory must tolerate req drop on rst.
// TESTING
//  1. Zero-wait mem, reset then 4 cycles -> imem_addr 0,4,8,C; ifid_pc4 4,8,C,10; ifid_valid=1 from cycle 2.
//  2. ack 3 cycles after req at pc=0x40 -> addr held 0x40 all 3 cycles; IF/ID loads only on ack.
//  3. stall=1 on ack of 0x8C620004 (lw) at pc=0x10 -> HOLD, req=0.
//     stall drops -> ifid_instr=0x8C620004, ifid_pc4=0x14, next addr 0x14.
//  4. redirect_pc=0x203 while fetch to 0x8 pending -> DRAIN; 0x8 data discarded; next addr 0x200; opcode=0 meanwhile.
//  5. flush & stall & ack same cycle -> ifid_valid=0, ifid_instr=0, acked instr in HOLD.
//  6. pc=32'hFFFFFFFC ack -> pc wraps to 0, ifid_pc4=0.
//     rst asserted mid-wait -> all outputs to reset values next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives a req/ack instruction-memory port and fills the
// IF/ID register. Redirects beat flush, flush beats stall and ack loads.
module fetch_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                flush,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                ifid_valid,
  output logic [31:0]         ifid_instr,
  output logic [PC_WIDTH-1:0] ifid_pc4,
  output logic [5:0]          opcode,
  output logic [1:0]          state_dbg
);

  // Memory handshake: a request is imem_req=1 with imem_addr held stable; it
  // completes on the cycle imem_ack=1 (possibly the first cycle of the request)
  // and imem_rdata is only meaningful in that cycle. Requests are never
  // withdrawn except by rst.

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] drain_addr_q;
  logic [31:0]         hold_q;
  logic                ifid_valid_q;
  logic [31:0]         ifid_instr_q;
  logic [PC_WIDTH-1:0] ifid_pc4_q;

  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] redirect_target;
  logic                unused_redirect_lsbs;

  assign pc_plus4             = pc_q + PC_STEP;
  assign redirect_target      = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req   = !rst && (state_q != S_HOLD);
  // While draining, pc already holds the redirect target; the bus keeps the stale address.
  assign imem_addr  = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign opcode     = ifid_instr_q[31:26];
  assign state_dbg  = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      hold_q       <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
    end else if (redirect_valid) begin
      pc_q         <= redirect_target;
      hold_q       <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      if (state_q != S_HOLD && !imem_ack) begin
        // Outstanding request must still complete; remember which address it was.
        state_q <= S_DRAIN;
        if (state_q == S_FETCH) drain_addr_q <= pc_q;
      end else begin
        state_q <= S_FETCH;
      end
    end else begin
      if (flush) begin
        ifid_valid_q <= 1'b0;
        ifid_instr_q <= '0;
      end
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            if (stall) begin
              hold_q  <= imem_rdata;
              state_q <= S_HOLD;
            end else begin
              pc_q <= pc_plus4;
              if (!flush) begin
                ifid_valid_q <= 1'b1;
                ifid_instr_q <= imem_rdata;
                ifid_pc4_q   <= pc_plus4;
              end
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc_q    <= pc_plus4;
            state_q <= S_FETCH;
            if (!flush) begin
              ifid_valid_q <= 1'b1;
              ifid_instr_q <= hold_q;
              ifid_pc4_q   <= pc_plus4;
            end
          end
        end
        S_DRAIN: begin
          if (imem_ack) state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected fetch addresses and IF/ID loads are
// queued by the stimulus and popped by a negedge monitor.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  opcode;
  logic [1:0]  state_dbg;

  logic        zw;
  logic        ack_man;
  logic [31:0] rdata_man;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_ifid_q[$];

  fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .opcode(opcode), .state_dbg(state_dbg)
  );

  // Zero-wait mode: memory acks in the request cycle with a lw-shaped word per address.
  assign imem_ack   = zw ? imem_req : ack_man;
  assign imem_rdata = zw ? (32'h8C000000 | {6'b0, imem_addr[25:0]}) : rdata_man;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_addr(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic push_ifid(input logic [31:0] instr, input logic [31:0] pc4);
    exp_ifid_q.push_back({instr, pc4});
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        prev_v = 1'b0;
  logic [31:0] prev_i = '0;
  logic [31:0] prev_p = '0;

  always @(negedge clk) begin
    logic [63:0] e;
    logic [31:0] ea;
    if (imem_req && imem_ack) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_fetch", imem_addr, 32'hxxxxxxxx);
      end else begin
        ea = exp_addr_q.pop_front();
        check("fetch_addr", imem_addr, ea);
      end
    end
    if (ifid_valid && (!prev_v || ifid_instr != prev_i || ifid_pc4 != prev_p)) begin
      if (exp_ifid_q.size() == 0) begin
        check("unexpected_ifid_load", ifid_instr, 32'hxxxxxxxx);
      end else begin
        e = exp_ifid_q.pop_front();
        check("ifid_instr", ifid_instr, e[63:32]);
        check("ifid_pc4", ifid_pc4, e[31:0]);
        check("opcode", {26'b0, opcode}, {26'b0, e[63:58]});
      end
    end
    if (!ifid_valid) begin
      check("bubble_instr", ifid_instr, 32'h0);
      check("bubble_opcode", {26'b0, opcode}, 32'h0);
    end
    prev_v = ifid_valid;
    prev_i = ifid_instr;
    prev_p = ifid_pc4;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; zw = 1'b0; ack_man = 1'b0; rdata_man = '0;
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state
    @(negedge clk);
    check("req_in_reset", {31'b0, imem_req}, 32'h0);
    cycle();
    rst = 1'b0;
    zw  = 1'b1;
    push_addr(32'h0); push_addr(32'h4); push_addr(32'h8); push_addr(32'hC);
    push_ifid(32'h8C000000, 32'h4);
    push_ifid(32'h8C000004, 32'h8);
    push_ifid(32'h8C000008, 32'hC);
    push_ifid(32'h8C00000C, 32'h10);
    @(negedge clk);
    check("rst_ifid_valid", {31'b0, ifid_valid}, 32'h0);
    check("rst_ifid_pc4", ifid_pc4, 32'h0);
    check("rst_state", {30'b0, state_dbg}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);

    // Zero-wait streaming, one instruction per cycle
    repeat (4) cycle();
    zw = 1'b0;

    // Stall on ack of lw at 0x10 -> HOLD
    ack_man = 1'b1; rdata_man = 32'h8C620004; stall = 1'b1;
    push_addr(32'h10);
    cycle();
    ack_man = 1'b0;
    @(negedge clk);
    check("hold_req", {31'b0, imem_req}, 32'h0);
    check("hold_state", {30'b0, state_dbg}, 32'h1);
    check("hold_ifid_kept", ifid_pc4, 32'h10);
    cycle();
    stall = 1'b0;
    push_ifid(32'h8C620004, 32'h14);
    cycle();
    @(negedge clk);
    check("after_hold_addr", imem_addr, 32'h14);

    // Redirect to 0x40 in the same cycle as an ack: data discarded, no drain
    redirect_valid = 1'b1; redirect_pc = 32'h40; ack_man = 1'b1; rdata_man = 32'hDEADBEEF;
    push_addr(32'h14);
    cycle();
    redirect_valid = 1'b0; ack_man = 1'b0;

    // Ack three cycles after the request at 0x40
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("wait_addr", imem_addr, 32'h40);
      check("wait_req", {31'b0, imem_req}, 32'h1);
      check("wait_ifid_valid", {31'b0, ifid_valid}, 32'h0);
      cycle();
    end
    ack_man = 1'b1; rdata_man = 32'h00851020;
    push_addr(32'h40);
    push_ifid(32'h00851020, 32'h44);
    cycle();
    ack_man = 1'b0;

    // Redirect with fetch to 0x44 outstanding -> DRAIN, newest target wins
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("drain_state", {30'b0, state_dbg}, 32'h2);
    check("drain_addr", imem_addr, 32'h44);
    check("drain_req", {31'b0, imem_req}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h301;
    cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("drain2_state", {30'b0, state_dbg}, 32'h2);
    check("drain2_addr", imem_addr, 32'h44);
    ack_man = 1'b1; rdata_man = 32'hFFFFFFFF;
    push_addr(32'h44);
    cycle();
    ack_man = 1'b0;
    @(negedge clk);
    check("post_drain_addr", imem_addr, 32'h300);
    check("post_drain_state", {30'b0, state_dbg}, 32'h0);

    // Flush & stall & ack in one cycle
    ack_man = 1'b1; rdata_man = 32'h24020005;
    push_addr(32'h300);
    push_ifid(32'h24020005, 32'h304);
    cycle();
    flush = 1'b1; stall = 1'b1; rdata_man = 32'h8D0A0008;
    push_addr(32'h304);
    cycle();
    flush = 1'b0; ack_man = 1'b0;
    @(negedge clk);
    check("flush_valid", {31'b0, ifid_valid}, 32'h0);
    check("flush_instr", ifid_instr, 32'h0);
    check("flush_state", {30'b0, state_dbg}, 32'h1);
    cycle();
    stall = 1'b0;
    push_ifid(32'h8D0A0008, 32'h308);
    cycle();
    @(negedge clk);
    check("after_flush_addr", imem_addr, 32'h308);

    // Wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFE; ack_man = 1'b1; rdata_man = 32'h12345678;
    push_addr(32'h308);
    cycle();
    redirect_valid = 1'b0; ack_man = 1'b0;
    @(negedge clk);
    check("top_addr", imem_addr, 32'hFFFFFFFC);
    ack_man = 1'b1; rdata_man = 32'h0000000C;
    push_addr(32'hFFFFFFFC);
    push_ifid(32'h0000000C, 32'h0);
    cycle();
    ack_man = 1'b0;
    @(negedge clk);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset while a fetch is waiting
    cycle();
    rst = 1'b1;
    cycle();
    @(negedge clk);
    check("midrst_req", {31'b0, imem_req}, 32'h0);
    check("midrst_valid", {31'b0, ifid_valid}, 32'h0);
    check("midrst_instr", ifid_instr, 32'h0);
    check("midrst_pc4", ifid_pc4, 32'h0);
    check("midrst_state", {30'b0, state_dbg}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req", {31'b0, imem_req}, 32'h1);
    check("post_rst_addr", imem_addr, 32'h0);

    repeat (2) cycle();
    check("addr_q_empty", exp_addr_q.size(), 32'h0);
    check("ifid_q_empty", exp_ifid_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
